// File: rtl/chart_player.sv
// rtl/chart_player.sv - beat-driven step-chart sequencer feeding the arrow shift register
module chart_player #(
    parameter int ADDR_W      = 6,
    parameter int CHART_LEN   = 64,
    parameter int LEAD_BEATS  = 8,
    parameter int FLUSH_BEATS = 8,
    parameter int LOOP        = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              beatPulse,
    output logic [ADDR_W-1:0] chartAddr,
    input  logic [3:0]        chartData,
    output logic [3:0]        step,
    output logic              stepStrobe,
    output logic              playing,
    output logic              done,
    output logic [ADDR_W-1:0] beatIdx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEADIN,
        S_PLAY,
        S_FLUSH,
        S_DONE
    } state_t;

    // Phases with a zero beat count are skipped inside the transition that would enter them.
    localparam state_t LEAD_ENTRY = (LEAD_BEATS != 0) ? S_LEADIN : S_PLAY;
    localparam state_t END_ENTRY  = (LOOP != 0) ? LEAD_ENTRY : S_DONE;
    localparam state_t PLAY_EXIT  = (FLUSH_BEATS != 0) ? S_FLUSH : END_ENTRY;

    localparam logic [ADDR_W:0]   PLAY_LAST = (ADDR_W+1)'(CHART_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CHART_LEN - 1);

    state_t            state;
    state_t            state_next;
    logic [7:0]        phase_cnt;
    logic [ADDR_W:0]   play_cnt;
    logic              consume;
    logic              enter;
    logic              last_item;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        if (state == S_PLAY) begin
            last_item = (play_cnt == PLAY_LAST);
        end else begin
            last_item = (phase_cnt == 8'd1);
        end
    end

    always_comb begin
        state_next = state;
        consume    = 1'b0;
        enter      = 1'b0;
        if (stop) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_next = LEAD_ENTRY;
                        enter      = 1'b1;
                    end
                end
                S_LEADIN: begin
                    if (beatPulse) begin
                        consume = 1'b1;
                        if (last_item) begin
                            state_next = S_PLAY;
                            enter      = 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (beatPulse) begin
                        consume = 1'b1;
                        if (last_item) begin
                            state_next = PLAY_EXIT;
                            enter      = 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (beatPulse) begin
                        consume = 1'b1;
                        if (last_item) begin
                            state_next = END_ENTRY;
                            enter      = 1'b1;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        playing = (state == S_LEADIN) || (state == S_PLAY) || (state == S_FLUSH);
        done    = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            chartAddr  <= '0;
            step       <= '0;
            stepStrobe <= 1'b0;
            beatIdx    <= '0;
            phase_cnt  <= '0;
            play_cnt   <= '0;
        end else begin
            stepStrobe <= consume;
            if (stop) begin
                chartAddr <= '0;
                step      <= '0;
                beatIdx   <= '0;
            end else begin
                if (consume) begin
                    if (state == S_PLAY) begin
                        step    <= chartData;
                        beatIdx <= play_cnt[ADDR_W-1:0];
                    end else begin
                        step    <= '0;
                        beatIdx <= '0;
                    end
                end else if (enter) begin
                    beatIdx <= '0;
                end

                if (enter) begin
                    phase_cnt <= (state_next == S_FLUSH) ? 8'(FLUSH_BEATS) : 8'(LEAD_BEATS);
                    play_cnt  <= '0;
                end else if (consume) begin
                    if (state == S_PLAY) begin
                        play_cnt <= play_cnt + 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                // Advancing right after a consumed beat leaves the ROM a full cycle before the next beat.
                if (enter && (state_next == S_LEADIN || state_next == S_PLAY)) begin
                    chartAddr <= '0;
                end else if (consume && state == S_PLAY && chartAddr != ADDR_LAST) begin
                    chartAddr <= chartAddr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chart_player.sv
// tb/tb_chart_player.sv - self-checking bench for chart_player: vector tables plus strobe scoreboard
module tb_chart_player;

    logic       clk = 1'b0;
    logic       reset;
    logic       start [3];
    logic       stop  [3];
    logic       beat  [3];
    logic [5:0] addr  [3];
    logic [5:0] idx   [3];
    logic [3:0] data  [3];
    logic [3:0] step_o[3];
    logic       strobe [3];
    logic       playing[3];
    logic       done_o [3];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         dut;
        logic [3:0] step;
        logic [5:0] idx;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [3:0] step;
        logic [5:0] idx;
        logic [5:0] addr;
        logic       playing;
        logic       done;
    } vec_t;

    exp_t sb[$];
    vec_t tab_a[7];
    vec_t tab_b[9];

    function automatic logic [3:0] rom3(input logic [5:0] a);
        case (a)
            6'd0:    return 4'h1;
            6'd1:    return 4'h2;
            6'd2:    return 4'h4;
            default: return 4'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        data[0] <= rom3(addr[0]);
        data[1] <= rom3(addr[1]);
        data[2] <= (addr[2] == 6'd0) ? 4'hF : 4'h0;
    end

    chart_player #(.ADDR_W(6), .CHART_LEN(3), .LEAD_BEATS(2), .FLUSH_BEATS(2), .LOOP(0)) u_once (
        .clk(clk), .reset(reset), .start(start[0]), .stop(stop[0]), .beatPulse(beat[0]),
        .chartAddr(addr[0]), .chartData(data[0]), .step(step_o[0]), .stepStrobe(strobe[0]),
        .playing(playing[0]), .done(done_o[0]), .beatIdx(idx[0]));

    chart_player #(.ADDR_W(6), .CHART_LEN(3), .LEAD_BEATS(2), .FLUSH_BEATS(2), .LOOP(1)) u_loop (
        .clk(clk), .reset(reset), .start(start[1]), .stop(stop[1]), .beatPulse(beat[1]),
        .chartAddr(addr[1]), .chartData(data[1]), .step(step_o[1]), .stepStrobe(strobe[1]),
        .playing(playing[1]), .done(done_o[1]), .beatIdx(idx[1]));

    chart_player #(.ADDR_W(6), .CHART_LEN(1), .LEAD_BEATS(0), .FLUSH_BEATS(0), .LOOP(0)) u_short (
        .clk(clk), .reset(reset), .start(start[2]), .stop(stop[2]), .beatPulse(beat[2]),
        .chartAddr(addr[2]), .chartData(data[2]), .step(step_o[2]), .stepStrobe(strobe[2]),
        .playing(playing[2]), .done(done_o[2]), .beatIdx(idx[2]));

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    // Sample on the falling edge; any strobe must match the oldest scoreboard entry.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (strobe[k] === 1'b1) begin
                if (sb.size() == 0 || sb[0].dut != k) begin
                    chk("unexpected_strobe", k, 32'(strobe[k]), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_cycle", k, 32'(cyc), 32'(e.cyc));
                    chk("step", k, 32'(step_o[k]), 32'(e.step));
                    chk("beat_idx", k, 32'(idx[k]), 32'(e.idx));
                end
            end
        end
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("missing_strobe", e.dut, 32'd0, 32'd1);
        end
    endtask

    task automatic do_beat(input int k, input bit expect_strobe, input logic [3:0] s, input logic [5:0] i);
        beat[k] = 1'b1;
        if (expect_strobe) sb.push_back('{dut: k, step: s, idx: i, cyc: cyc + 1});
        tick();
        chk("strobe_level", k, 32'(strobe[k]), 32'(expect_strobe));
        beat[k] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    task automatic check_reset_values(input int k);
        chk("rst_step", k, 32'(step_o[k]), 32'd0);
        chk("rst_strobe", k, 32'(strobe[k]), 32'd0);
        chk("rst_playing", k, 32'(playing[k]), 32'd0);
        chk("rst_done", k, 32'(done_o[k]), 32'd0);
        chk("rst_addr", k, 32'(addr[k]), 32'd0);
        chk("rst_idx", k, 32'(idx[k]), 32'd0);
    endtask

    initial begin
        tab_a[0] = '{4'h0, 6'd0, 6'd0, 1'b1, 1'b0};
        tab_a[1] = '{4'h0, 6'd0, 6'd0, 1'b1, 1'b0};
        tab_a[2] = '{4'h1, 6'd0, 6'd1, 1'b1, 1'b0};
        tab_a[3] = '{4'h2, 6'd1, 6'd2, 1'b1, 1'b0};
        tab_a[4] = '{4'h4, 6'd2, 6'd2, 1'b1, 1'b0};
        tab_a[5] = '{4'h0, 6'd0, 6'd2, 1'b1, 1'b0};
        tab_a[6] = '{4'h0, 6'd0, 6'd2, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) tab_b[i] = tab_a[i];
        tab_b[6] = '{4'h0, 6'd0, 6'd0, 1'b1, 1'b0};
        tab_b[7] = '{4'h0, 6'd0, 6'd0, 1'b1, 1'b0};
        tab_b[8] = '{4'h0, 6'd0, 6'd0, 1'b1, 1'b0};

        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            stop[k]  = 1'b0;
            beat[k]  = 1'b0;
        end
        repeat (3) tick();
        for (int k = 0; k < 3; k++) check_reset_values(k);
        reset = 1'b1;
        tick();

        do_beat(0, 1'b0, 4'h0, 6'd0);
        chk("idle_step", 0, 32'(step_o[0]), 32'd0);

        // One-shot song; start pulse during PLAY must be ignored.
        pulse_start(0);
        chk("start_playing", 0, 32'(playing[0]), 32'd1);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) pulse_start(0);
            do_beat(0, 1'b1, tab_a[i].step, tab_a[i].idx);
            chk("playing", 0, 32'(playing[0]), 32'(tab_a[i].playing));
            chk("done", 0, 32'(done_o[0]), 32'(tab_a[i].done));
            chk("chart_addr", 0, 32'(addr[0]), 32'(tab_a[i].addr));
        end

        do_beat(0, 1'b0, 4'h0, 6'd0);
        chk("done_hold", 0, 32'(done_o[0]), 32'd1);
        pulse_start(0);
        chk("restart_playing", 0, 32'(playing[0]), 32'd1);
        chk("restart_done", 0, 32'(done_o[0]), 32'd0);
        chk("restart_idx", 0, 32'(idx[0]), 32'd0);
        chk("restart_addr", 0, 32'(addr[0]), 32'd0);
        do_beat(0, 1'b1, 4'h0, 6'd0);
        do_beat(0, 1'b1, 4'h0, 6'd0);
        do_beat(0, 1'b1, 4'h1, 6'd0);
        do_beat(0, 1'b1, 4'h2, 6'd1);

        // stop wins over a coincident beat.
        stop[0] = 1'b1;
        beat[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        beat[0] = 1'b0;
        chk("stop_strobe", 0, 32'(strobe[0]), 32'd0);
        chk("stop_step", 0, 32'(step_o[0]), 32'd0);
        chk("stop_playing", 0, 32'(playing[0]), 32'd0);
        chk("stop_done", 0, 32'(done_o[0]), 32'd0);
        chk("stop_addr", 0, 32'(addr[0]), 32'd0);
        tick();

        // start with a coincident beat enters lead-in without consuming the beat.
        start[0] = 1'b1;
        beat[0]  = 1'b1;
        tick();
        start[0] = 1'b0;
        beat[0]  = 1'b0;
        chk("start_beat_strobe", 0, 32'(strobe[0]), 32'd0);
        chk("start_beat_playing", 0, 32'(playing[0]), 32'd1);
        tick();
        do_beat(0, 1'b1, 4'h0, 6'd0);
        do_beat(0, 1'b1, 4'h0, 6'd0);
        do_beat(0, 1'b1, 4'h1, 6'd0);
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;

        // Looping song never reaches DONE.
        pulse_start(1);
        for (int i = 0; i < 9; i++) begin
            do_beat(1, 1'b1, tab_b[i].step, tab_b[i].idx);
            chk("loop_playing", 1, 32'(playing[1]), 32'(tab_b[i].playing));
            chk("loop_done", 1, 32'(done_o[1]), 32'(tab_b[i].done));
            chk("loop_addr", 1, 32'(addr[1]), 32'(tab_b[i].addr));
        end
        do_beat(1, 1'b1, 4'h1, 6'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset_values(1);
        tick();

        // Zero lead-in/flush, single-entry chart.
        pulse_start(2);
        chk("short_playing", 2, 32'(playing[2]), 32'd1);
        repeat (3) tick();
        do_beat(2, 1'b1, 4'hF, 6'd0);
        chk("short_done", 2, 32'(done_o[2]), 32'd1);
        chk("short_playing_end", 2, 32'(playing[2]), 32'd0);
        do_beat(2, 1'b0, 4'h0, 6'd0);
        chk("short_step_hold", 2, 32'(step_o[2]), 32'hF);

        repeat (2) tick();
        chk("scoreboard_empty", 0, 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
